// File: rtl/lpfull_decimate_pack.sv
// Decimate-by-2 and pack: keeps every other lane of two consecutive 8-lane words,
// saturates each kept sample to OUTBITS and emits one packed 8-lane word per pair.
module lpfull_decimate_pack #(
    parameter int INBITS      = 13,
    parameter int OUTBITS     = 12,
    parameter int DECIM_PHASE = 0,
    localparam int NSAMPS     = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NSAMPS-1:0][INBITS-1:0]    dat_i,
    input  logic                             sync_i,
    input  logic                             sat_clr_i,
    output logic [NSAMPS-1:0][OUTBITS-1:0]   dat_o,
    output logic                             valid_o,
    output logic [15:0]                      sat_cnt_o
);

    localparam int unsigned NKEEP = NSAMPS / 2;
    localparam int unsigned PH    = (DECIM_PHASE != 0) ? 1 : 0;

    localparam logic [OUTBITS-1:0] POS_MAX = {1'b0, {(OUTBITS-1){1'b1}}};
    localparam logic [OUTBITS-1:0] NEG_MIN = {1'b1, {(OUTBITS-1){1'b0}}};

    typedef enum logic {PH0, PH1} phase_t;

    phase_t ph;
    phase_t ph_next;
    phase_t word_ph;

    logic [NKEEP-1:0][OUTBITS-1:0] kept_sat;
    logic [NKEEP-1:0][OUTBITS-1:0] hold;
    logic [NKEEP-1:0]              clip;
    logic [2:0]                    clip_cnt;
    logic [16:0]                   cnt_sum;
    logic [15:0]                   cnt_next;

    // A sample clips when its discarded top bits are not a pure sign extension.
    always_comb begin
        kept_sat = '0;
        clip     = '0;
        clip_cnt = '0;
        for (int unsigned k = 0; k < NKEEP; k++) begin
            clip[k] = !((&dat_i[2*k+PH][INBITS-1:OUTBITS-1]) ||
                        !(|dat_i[2*k+PH][INBITS-1:OUTBITS-1]));
            if (clip[k]) begin
                kept_sat[k] = dat_i[2*k+PH][INBITS-1] ? NEG_MIN : POS_MAX;
            end else begin
                kept_sat[k] = dat_i[2*k+PH][OUTBITS-1:0];
            end
            clip_cnt = clip_cnt + 3'(clip[k]);
        end
        cnt_sum  = {1'b0, sat_cnt_o} + 17'(clip_cnt);
        cnt_next = sat_clr_i ? 16'(clip_cnt) : (cnt_sum[16] ? '1 : cnt_sum[15:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph <= PH0;
        end else begin
            ph <= ph_next;
        end
    end

    // sync_i overrides the running phase so the current word always starts a pair.
    always_comb begin
        word_ph = sync_i ? PH0 : ph;
        ph_next = (word_ph == PH0) ? PH1 : PH0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold      <= '0;
            dat_o     <= '0;
            valid_o   <= 1'b0;
            sat_cnt_o <= '0;
        end else begin
            sat_cnt_o <= cnt_next;
            valid_o   <= 1'b0;
            if (word_ph == PH0) begin
                hold <= kept_sat;
            end else begin
                dat_o   <= {kept_sat, hold};
                valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lpfull_decimate_pack.sv
// Scoreboard bench: two DUTs (even/odd lane selection) share stimulus and are
// checked against a clamp-and-queue reference model every cycle.
module tb_lpfull_decimate_pack;

    typedef logic [7:0][11:0] oword_t;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [7:0][12:0]  dat_i;
    logic              sync_i;
    logic              sat_clr_i;
    oword_t            dat0, dat1;
    logic              valid0, valid1;
    logic [15:0]       cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    lpfull_decimate_pack #(.INBITS(13), .OUTBITS(12), .DECIM_PHASE(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .sync_i(sync_i),
        .sat_clr_i(sat_clr_i), .dat_o(dat0), .valid_o(valid0), .sat_cnt_o(cnt0));

    lpfull_decimate_pack #(.INBITS(13), .OUTBITS(12), .DECIM_PHASE(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .sync_i(sync_i),
        .sat_clr_i(sat_clr_i), .dat_o(dat1), .valid_o(valid1), .sat_cnt_o(cnt1));

    always #5 clk = ~clk;

    // Reference model state
    int     lane[8];
    int     mph = 0;
    int     hold[2][4];
    int     cnt[2];
    bit     expv[2];
    oword_t held[2];
    oword_t q0[$];
    oword_t q1[$];

    function automatic int satv(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic model_reset();
        mph = 0;
        for (int p = 0; p < 2; p++) begin
            cnt[p]  = 0;
            expv[p] = 1'b0;
            held[p] = '0;
            for (int k = 0; k < 4; k++) hold[p][k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Called at a negedge: drives one word, advances the model, returns at the next negedge.
    task automatic step(input bit s, input bit c);
        int     wph;
        int     clips;
        int     sv;
        oword_t w;
        for (int i = 0; i < 8; i++) dat_i[i] = lane[i][12:0];
        sync_i    = s;
        sat_clr_i = c;
        wph = s ? 0 : mph;
        for (int p = 0; p < 2; p++) begin
            clips = 0;
            w = '0;
            for (int k = 0; k < 4; k++) begin
                sv = satv(lane[2*k+p]);
                if (sv != lane[2*k+p]) clips++;
                if (wph == 0) begin
                    hold[p][k] = sv;
                end else begin
                    w[k]   = hold[p][k][11:0];
                    w[k+4] = sv[11:0];
                end
            end
            if (wph == 0) begin
                expv[p] = 1'b0;
            end else begin
                expv[p] = 1'b1;
                if (p == 0) q0.push_back(w); else q1.push_back(w);
            end
            if (c) cnt[p] = clips;
            else cnt[p] = (cnt[p] + clips > 65535) ? 65535 : cnt[p] + clips;
        end
        mph = 1 - wph;
        @(negedge clk);
    endtask

    task automatic chk(input int idx, input logic v, input oword_t d, input logic [15:0] c);
        oword_t e;
        bit     empty;
        checks++;
        if (v !== expv[idx]) begin
            failures++;
            $display("FAIL valid dut%0d t=%0t got=%b exp=%b", idx, $time, v, expv[idx]);
        end
        checks++;
        if (c !== 16'(cnt[idx])) begin
            failures++;
            $display("FAIL sat_cnt dut%0d t=%0t got=%0d exp=%0d", idx, $time, c, cnt[idx]);
        end
        if (v === 1'b1) begin
            empty = (idx == 0) ? (q0.size() == 0) : (q1.size() == 0);
            checks++;
            if (empty) begin
                failures++;
                $display("FAIL unexpected_word dut%0d t=%0t got=%h exp=none", idx, $time, d);
            end else begin
                e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                held[idx] = e;
                if (d !== e) begin
                    failures++;
                    $display("FAIL dat dut%0d t=%0t got=%h exp=%h", idx, $time, d, e);
                end
            end
        end else begin
            checks++;
            if (d !== held[idx]) begin
                failures++;
                $display("FAIL dat_hold dut%0d t=%0t got=%h exp=%h", idx, $time, d, held[idx]);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk(0, valid0, dat0, cnt0);
        chk(1, valid1, dat1, cnt1);
    end

    task automatic rand_lanes();
        for (int i = 0; i < 8; i++) lane[i] = int'($urandom_range(8191)) - 4096;
    endtask

    initial begin
        oword_t e0, e1;
        rst_i = 1'b1;
        dat_i = '0;
        sync_i = 1'b0;
        sat_clr_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        // Ramp pair
        for (int i = 0; i < 8; i++) lane[i] = i;
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) lane[i] = 8 + i;
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            e0[i] = 12'(2 * i);
            e1[i] = 12'(2 * i + 1);
        end
        checks++;
        if (!(valid0 === 1'b1 && dat0 === e0)) begin
            failures++;
            $display("FAIL ramp_even got=%h exp=%h", dat0, e0);
        end
        checks++;
        if (!(valid1 === 1'b1 && dat1 === e1)) begin
            failures++;
            $display("FAIL ramp_odd got=%h exp=%h", dat1, e1);
        end

        // Saturation on the phase-0 half, odd lanes random
        rand_lanes();
        lane[0] = 2100; lane[2] = -2100; lane[4] = 2047; lane[6] = -2048;
        step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) lane[i] = i * 100 - 300;
        step(1'b0, 1'b0);

        // Resync back to back
        rand_lanes(); step(1'b1, 1'b0);
        rand_lanes(); step(1'b1, 1'b0);
        for (int n = 0; n < 4; n++) begin rand_lanes(); step(1'b0, 1'b0); end

        // sync held: every word phase 0
        for (int n = 0; n < 10; n++) begin rand_lanes(); step(1'b1, 1'b0); end

        // Random traffic with occasional sync / clear
        for (int n = 0; n < 2000; n++) begin
            rand_lanes();
            step($urandom_range(15) == 0, $urandom_range(31) == 0);
        end

        // Asynchronous reset between the halves of a pair
        rand_lanes(); step(1'b1, 1'b0);
        #1 rst_i = 1'b1;
        #1;
        checks++;
        if (!(valid0 === 1'b0 && dat0 === '0 && cnt0 === 16'h0 &&
              valid1 === 1'b0 && dat1 === '0 && cnt1 === 16'h0)) begin
            failures++;
            $display("FAIL async_reset got v=%b%b c=%0d/%0d exp=0", valid0, valid1, cnt0, cnt1);
        end
        model_reset();
        @(negedge clk);
        rst_i = 1'b0;
        for (int n = 0; n < 200; n++) begin
            rand_lanes();
            step($urandom_range(15) == 0, 1'b0);
        end

        // Counter saturation: even lanes +4000, odd lanes -4000
        for (int n = 0; n < 16400; n++) begin
            for (int i = 0; i < 8; i++) lane[i] = (i % 2 == 0) ? 4000 : -4000;
            step(1'b0, 1'b0);
        end
        checks++;
        if (cnt0 !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_saturate got=%h exp=ffff", cnt0);
        end
        step(1'b0, 1'b1);
        checks++;
        if (cnt0 !== 16'd4) begin
            failures++;
            $display("FAIL cnt_clear got=%0d exp=4", cnt0);
        end
        for (int i = 0; i < 8; i++) lane[i] = (i % 2 == 0) ? 0 : -4000;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (cnt0 !== 16'd4) begin
            failures++;
            $display("FAIL cnt_odd_ignored got=%0d exp=4", cnt0);
        end

        for (int n = 0; n < 4; n++) begin rand_lanes(); step(1'b0, 1'b0); end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d/%0d exp=0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
